mer_measure_ctrl: RTL

MER_MEASURE_CTRL -- requirements
Module: mer_measure_ctrl

---
 rtl/mer_measure_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mer_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mer_measure_ctrl
// Description : Modulation-error-ratio measurement controller for a 4-ASK
//               receiver. After a start request it discards SETTLE_SYMS
//               symbols. It then estimates the inner level amplitude "a" from
//               the mean of |x| over 2^LOG2_LEN symbols. Next it slices a
//               further 2^LOG2_LEN symbols against {+-a, +-3a} and averages
//               the squared slicer error. Results are published on a one-cycle
//               done pulse.
// Ports       : sys_clk       system clock, all logic on rising edge
//               reset_n       asynchronous active-low reset
//               sym_clk_ena   one-cycle symbol strobe (decision_var valid)
//               decision_var  signed 1s17 receive filter output
//               start         level-sampled measurement request
//               abort         return to IDLE, discard partial results
//               busy          high whenever the FSM is not in IDLE
//               done          one-cycle pulse when results update
//               level_a       estimated inner amplitude "a" (1s17 scale)
//               err_mean      mean squared slicer error
// Options     : MER_CONTINUOUS_EN - when defined, the FSM goes from DONE
//               directly into a new LEVEL phase (back-to-back measurements
//               until abort); when undefined every run needs a start.
// Revision    : 1.0 - initial release
// ============================================================================
module mer_measure_ctrl #(
  parameter int SETTLE_SYMS = 64,
  parameter int LOG2_LEN    = 10
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        sym_clk_ena,
  input  logic [17:0] decision_var,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [17:0] level_a,
  output logic [17:0] err_mean
);

  localparam int ACC_W = 18 + LOG2_LEN;
  localparam int SET_W = (SETTLE_SYMS > 1) ? $clog2(SETTLE_SYMS) : 1;
  localparam int CNT_W = (SET_W > LOG2_LEN) ? SET_W : LOG2_LEN;
  localparam logic [CNT_W-1:0] SETTLE_LAST =
      CNT_W'((SETTLE_SYMS > 0) ? SETTLE_SYMS - 1 : 0);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'((1 << LOG2_LEN) - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    LEVEL  = 3'd2,
    ERROR  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_lvl_acc;
  logic [ACC_W-1:0]   r_err_acc;
  logic [17:0]        r_a;

  // |x| with the single unrepresentable magnitude (-2^17) clamped.
  logic [17:0] w_neg_x;
  logic [16:0] w_abs_x;
  assign w_neg_x = ~decision_var + 18'd1;
  assign w_abs_x = decision_var[17]
                 ? ((decision_var == 18'h20000) ? 17'h1FFFF : w_neg_x[16:0])
                 : decision_var[16:0];

  // Slicer and squared error. 20-bit signed math holds +-3a and x - level
  // without overflow; the error itself always fits in 19 bits because the
  // chosen level has the same sign as x.
  logic signed [19:0] w_x, w_a, w_t, w_a3, w_lvl, w_err;
  logic signed [39:0] w_sq;
  logic [17:0]        w_term;

  assign w_x  = {{2{decision_var[17]}}, decision_var};
  assign w_a  = {2'b00, r_a};
  assign w_t  = w_a + w_a;
  assign w_a3 = w_a + w_t;

  // Ties resolve outward (x == T -> 3a, x == -T -> -3a); zero is positive.
  always_comb begin
    w_lvl = -w_a3;
    if (w_x >= w_t)        w_lvl = w_a3;
    else if (w_x >= 20'sd0) w_lvl = w_a;
    else if (w_x > -w_t)   w_lvl = -w_a;
  end

  assign w_err  = w_x - w_lvl;
  assign w_sq   = w_err * w_err;
  assign w_term = w_sq[35:18];

  logic w_unused_bits;
  assign w_unused_bits = ^{w_neg_x[17], w_sq[39:36], w_sq[17:0]};

  // Running sums including the current symbol, so the last strobe of a
  // phase is folded in on the same edge that leaves the phase.
  logic [ACC_W-1:0] w_lvl_sum;
  logic [ACC_W-1:0] w_err_sum;
  logic [17:0]      w_a_new;
  logic [17:0]      w_mean_new;

  assign w_lvl_sum  = r_lvl_acc + ACC_W'(w_abs_x);
  assign w_err_sum  = r_err_acc + ACC_W'(w_term);
  // mean|x| = 2a for an even mix of a and 3a, hence the extra shift by one.
  assign w_a_new    = {1'b0, w_lvl_sum[ACC_W-1:LOG2_LEN+1]};
  assign w_mean_new = w_err_sum[ACC_W-1:LOG2_LEN];

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_lvl_acc <= '0;
      r_err_acc <= '0;
      r_a       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      level_a   <= '0;
      err_mean  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_lvl_acc <= '0;
        r_err_acc <= '0;
        r_a       <= '0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state   <= SETTLE;
              r_cnt     <= '0;
              r_lvl_acc <= '0;
              r_err_acc <= '0;
              r_a       <= '0;
              busy      <= 1'b1;
            end
          end

          SETTLE: begin
            if (SETTLE_SYMS == 0) begin
              r_state <= LEVEL;
              r_cnt   <= '0;
            end else if (sym_clk_ena) begin
              if (r_cnt == SETTLE_LAST) begin
                r_state <= LEVEL;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end

          LEVEL: begin
            if (sym_clk_ena) begin
              r_lvl_acc <= w_lvl_sum;
              if (r_cnt == PHASE_LAST) begin
                r_state <= ERROR;
                r_cnt   <= '0;
                r_a     <= w_a_new;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end

          ERROR: begin
            if (sym_clk_ena) begin
              r_err_acc <= w_err_sum;
              if (r_cnt == PHASE_LAST) begin
                // Results and done register together so they are visible
                // during the single DONE cycle.
                r_state  <= DONE;
                r_cnt    <= '0;
                done     <= 1'b1;
                level_a  <= r_a;
                err_mean <= w_mean_new;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end

          DONE: begin
`ifdef MER_CONTINUOUS_EN
            r_state   <= LEVEL;
            r_cnt     <= '0;
            r_lvl_acc <= '0;
            r_err_acc <= '0;
`else
            r_state <= IDLE;
            busy    <= 1'b0;
`endif
          end

          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
